product_bcd_converter: RTL and testbench
========================================

# product_bcd_converter

Sequential binary-to-BCD converter that consumes the 8-bit result of the 4x4 unsigned multiplier (product_high:product_low) and produces three BCD digits for the ALU display path. It sits directly downstream of the multiplier. It captures the product on a start strobe, runs an 8-iteration shift-and-add-3 (double-dabble) sequence, and presents registered digits with a one-cycle done pulse.

## Interface
- No parameters: widths are fixed to the multiplier's 8-bit product and 3 BCD digits.
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request conversion; sampled only in IDLE
- product_low  input  4  multiplier product bits [3:0]
- product_high  input  4  multiplier product bits [7:4]
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when digits are updated
- bcd_hundreds  output  4  hundreds digit (0..2)
- bcd_tens  output  4  tens digit (0..9)
- bcd_ones  output  4  ones digit (0..9)

## Operation
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, all bcd_* = 4'd0, iteration counter=0, internal shift register=0. All of these hold while rst_n is low.
- States: IDLE, SHIFT.
- IDLE, start=1 at an edge: capture {product_high, product_low} into the 8-bit binary field of a 20-bit shift register (12-bit BCD field cleared), counter=0, busy=1, go to SHIFT.
- IDLE, start=0: hold; bcd_* keep their last value.
- SHIFT, each edge, in order:
  - For each BCD nibble of the current register value >= 5, add 3 to that nibble.
  - Shift the whole 20-bit register left by 1.
  - Increment the counter.
- SHIFT, on the edge that completes iteration 8 (counter reaches 8):
  - Load bcd_hundreds/tens/ones from the post-shift BCD field.
  - done=1, busy=0, return to IDLE.
- done lasts exactly one cycle. It clears on the next edge regardless of start.
- start while in SHIFT is ignored; no queuing.
- Inputs are sampled only on the capture edge. Later changes to product_* do not affect the conversion in flight.
- Result is exact for all 0..255. For multiplier outputs (max 225), bcd_hundreds <= 2.
- bcd_* change only on the done edge or on reset. They hold the previous result throughout a new conversion.

## Timing
- Capture edge E0: start=1 in IDLE; busy rises after E0.
- Edges E1..E8 perform iterations 1..8.
- After E8: bcd_* valid, done=1, busy=0.
- After E9: done=0.
- Latency: 8 cycles from the capture edge to done high.
- Back-to-back: the earliest next capture is E9 (start high during the done cycle). Throughput is one conversion per 9 cycles.
- Reset asserted mid-conversion: immediate return to the reset values above, and no done pulse is produced. After rst_n deassertion the block is in IDLE and needs a fresh start.
- busy and done are never high in the same cycle.

## Test plan
- Reset and idle: hold rst_n low 3 cycles, then release with start=0 for 5 cycles -> busy=0, done=0, all bcd_*=0 throughout.
- Maximum product: high=4'hE, low=4'h1 (225 = 15x15), start pulse -> done exactly 8 cycles after the capture edge; digits 2/2/5; busy high for 8 cycles.
- Zero and two-digit cases: 0x00 -> 0/0/0; 0x63 (99) -> 0/9/9; 0x24 (36 = 9x4) -> 0/3/6; 0x06 (6 = 2x3) -> 0/0/6.
- Start while busy: start at E0 with 0x19 (25), hold start high and change product to 0xFF during E1..E7 -> single done at E8 with digits 0/2/5; next capture at E9 (start still high) converts 0xFF -> 2/5/5 at E17.
- Reset mid-conversion: start with 0x12 (18), assert rst_n low after E4 -> busy, done and bcd_* drop to 0 immediately and no done is produced. New start with 0x32 (50) -> 0/5/0.
- Hold behaviour: after a 225 conversion, change product_* with start=0 for 10 cycles -> bcd_* remain 2/2/5 and done stays 0.

Source files
------------

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for the 8-bit multiplier product.
// Runs an 8-step shift-and-add-3 sequence and presents registered digits with a done pulse.
module product_bcd_converter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] product_low,
    input  logic [3:0] product_high,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Double-dabble correction for one BCD nibble.
    function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [19:0] shift_r;
    logic [19:0] shift_nxt_s;
    logic [19:0] shift_adj_s;
    logic [19:0] shift_step_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic [3:0]  cnt_inc_s;
    logic        busy_r;
    logic        busy_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic [11:0] bcd_r;
    logic [11:0] bcd_nxt_s;

    // One iteration: correct every BCD nibble, then shift the whole register left.
    always_comb begin
        shift_adj_s  = {add3_nibble(shift_r[19:16]),
                        add3_nibble(shift_r[15:12]),
                        add3_nibble(shift_r[11:8]),
                        shift_r[7:0]};
        shift_step_s = shift_adj_s << 1;
        cnt_inc_s    = cnt_r + 4'd1;
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        bcd_nxt_s   = bcd_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    shift_nxt_s = {12'd0, product_high, product_low};
                    cnt_nxt_s   = 4'd0;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_SHIFT: begin
                shift_nxt_s = shift_step_s;
                cnt_nxt_s   = cnt_inc_s;
                if (cnt_inc_s == 4'd8) begin
                    // Digits come from the post-shift BCD field of the final iteration.
                    bcd_nxt_s   = shift_step_s[19:8];
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
                shift_nxt_s = 20'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shift_r <= 20'd0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= 12'd0;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            bcd_r   <= bcd_nxt_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign bcd_hundreds = bcd_r[11:8];
    assign bcd_tens     = bcd_r[7:4];
    assign bcd_ones     = bcd_r[3:0];

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter against a decimal-arithmetic reference.
module tb_product_bcd_converter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] product_low;
    logic [3:0] product_high;
    logic       busy;
    logic       done;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    int checks = 0;
    int errors = 0;

    product_bcd_converter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .product_low  (product_low),
        .product_high (product_high),
        .busy         (busy),
        .done         (done),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of the value via plain division.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [11:0] digits();
        return {bcd_hundreds, bcd_tens, bcd_ones};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; product_high = 4'h7; product_low = 4'h3;
        #1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || digits() !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, digits());
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || digits() !== 12'h000) begin
                errors++;
                $display("FAIL idle_after_reset: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, digits());
            end
        end
    endtask

    task automatic test_max();
        logic [11:0] old_d;
        old_d = digits();
        {product_high, product_low} = 8'hE1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        product_high = 4'h0; product_low = 4'h0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL max_capture: busy=%b done=%b expected 1 0", busy, done);
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            checks++;
            if (c < 8) begin
                if (busy !== 1'b1 || done !== 1'b0 || digits() !== old_d) begin
                    errors++;
                    $display("FAIL max_busy_c%0d: busy=%b done=%b bcd=%h expected 1 0 %h", c, busy, done, digits(), old_d);
                end
            end else begin
                if (busy !== 1'b0 || done !== 1'b1 || digits() !== ref_bcd(225)) begin
                    errors++;
                    $display("FAIL max_done: busy=%b done=%b bcd=%h expected 0 1 %h", busy, done, digits(), ref_bcd(225));
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_done_clear: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_patterns();
        int vals[$];
        vals = '{0, 99, 36, 6, 255, 100, 200, 9, 10, 199};
        for (int i = 0; i < 16; i++) vals.push_back(int'($urandom_range(255)));
        foreach (vals[i]) begin
            int lat;
            bit got;
            bit overlap;
            {product_high, product_low} = 8'(vals[i]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            product_high = 4'($urandom); product_low = 4'($urandom);
            lat = 0; got = 1'b0; overlap = 1'b0;
            for (int c = 1; c <= 20 && !got; c++) begin
                @(posedge clk); #1;
                if (busy && done) overlap = 1'b1;
                if (done) begin
                    got = 1'b1;
                    lat = c;
                end
            end
            checks++;
            if (!got || lat != 8 || overlap) begin
                errors++;
                $display("FAIL pattern_latency v=%0d: got=%0b latency=%0d overlap=%0b expected 1 8 0", vals[i], got, lat, overlap);
            end
            checks++;
            if (digits() !== ref_bcd(vals[i])) begin
                errors++;
                $display("FAIL pattern_digits v=%0d: bcd=%h expected %h", vals[i], digits(), ref_bcd(vals[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        {product_high, product_low} = 8'h19;
        start = 1'b1;
        @(posedge clk); #1;
        {product_high, product_low} = 8'hFF;
        dones = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones != 1 || done !== 1'b1 || digits() !== ref_bcd(25)) begin
            errors++;
            $display("FAIL b2b_first: dones=%0d done=%b bcd=%h expected 1 1 %h", dones, done, digits(), ref_bcd(25));
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_recapture: busy=%b done=%b expected 1 0", busy, done);
        end
        dones = 0;
        for (int c = 10; c <= 16; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        @(posedge clk); #1;
        checks++;
        if (dones != 0 || done !== 1'b1 || digits() !== ref_bcd(255)) begin
            errors++;
            $display("FAIL b2b_second: early_dones=%0d done=%b bcd=%h expected 0 1 %h", dones, done, digits(), ref_bcd(255));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit got;
        {product_high, product_low} = 8'h12;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || digits() !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, digits());
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done || busy) got = 1'b1;
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL reset_mid_no_done: activity=%0b expected 0", got);
        end
        {product_high, product_low} = 8'h32;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        checks++;
        if (!got || digits() !== ref_bcd(50)) begin
            errors++;
            $display("FAIL reset_mid_restart: got=%0b bcd=%h expected 1 %h", got, digits(), ref_bcd(50));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        bit got;
        bit bad;
        {product_high, product_low} = 8'hE1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        checks++;
        if (!got || digits() !== ref_bcd(225)) begin
            errors++;
            $display("FAIL hold_setup: got=%0b bcd=%h expected 1 %h", got, digits(), ref_bcd(225));
        end
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            product_high = 4'($urandom); product_low = 4'($urandom);
            if (c > 0 && (done !== 1'b0 || busy !== 1'b0 || digits() !== ref_bcd(225))) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_digits: bcd=%h done=%b expected %h 0", digits(), done, ref_bcd(225));
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
